rand_pkt_ctrl: RTL and testbench
================================

# rand_pkt_ctrl

Sequencer for the random data generator (`gen_rand`) in the data-generation simulation environment. It seeds the generator, draws a random length for each packet, and frames the generator's free-running output into SOP/EOP-delimited packets. Packets go out on a valid/ready stream with configurable inter-packet gaps. It sits between the test controller and the cache input ports.

## Interface
Parameters:
- `DW`, default 32: data width; must match the generator's `DW`.
- `RW`, default 32: seed width.
- `LEN_W`, default 8: packet-length field width; `LEN_W <= DW`.
- `PW`, default 16: packet-count width.
- `GW`, default 8: gap-count width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_start` in 1: run request; sampled only in IDLE.
- `i_seed` in RW: seed, latched on an accepted `i_start`.
- `i_pkt_num` in PW: number of packets to send, latched on start.
- `i_len_mask` in LEN_W: length mask, latched on start.
- `i_gap` in GW: idle cycles between packets, latched on start.
- `i_stop` in 1: graceful stop request, level-sensitive.
- `i_rand_data` in DW: generator output.
- `o_load` out 1: seed load strobe to the generator.
- `o_seed` out RW: seed to the generator.
- `i_ready` in 1: downstream ready.
- `o_valid` out 1: data valid.
- `o_data` out DW: payload word.
- `o_sop` out 1: first beat of a packet.
- `o_eop` out 1: last beat of a packet.
- `o_busy` out 1: high in any state other than IDLE.
- `o_done` out 1: one-cycle pulse at the end of a run.
- `o_pkt_cnt` out PW: packets completed in the current or last run.

## Operation
States: IDLE, LOAD, LEN, DATA, GAP.

- **IDLE**
  - If `i_start` is high and `i_pkt_num != 0`: latch the seed, count, mask and gap; clear `o_pkt_cnt`; go to LOAD.
  - If `i_start` is high and `i_pkt_num == 0`: pulse `o_done` next cycle; stay in IDLE; no load.
- **LOAD**
  - `o_load = 1` for exactly one cycle, with `o_seed` = the latched seed.
  - Go to LEN.
- **LEN** (one cycle)
  - Capture `len = (i_rand_data[LEN_W-1:0] & mask) + 1`, computed at LEN_W+1 bits, so the range is 1..mask+1.
  - Capture the hold register from `i_rand_data`.
  - Clear the beat counter; go to DATA.
- **DATA**
  - `o_valid = 1`, `o_data` = hold register.
  - `o_sop` = (beat == 0); `o_eop` = (beat == len-1).
  - On each handshake (`o_valid && i_ready`): reload the hold register from `i_rand_data` and increment the beat counter.
  - With `i_ready` low: `o_data`, `o_sop` and `o_eop` are held stable.
  - On the EOP handshake: increment `o_pkt_cnt`. Then:
    - If the new count == `pkt_num`, or `i_stop` is high: go to IDLE and pulse `o_done`.
    - Else if gap == 0: go to LEN.
    - Else: go to GAP.
- **GAP**
  - Count `gap` cycles with `o_valid = 0`, then go to LEN.
  - If `i_stop` is high in GAP: go to IDLE and pulse `o_done`.
- Boundary rules:
  - `i_stop` never truncates a packet.
  - `i_start` is ignored while busy.
  - A single-beat packet (len = 1) asserts `o_sop` and `o_eop` together.
  - `o_pkt_cnt` saturates at `pkt_num` and holds after `o_done` until the next accepted start.
  - The generator is not reseeded between packets within a run.

## Timing
- Reset values: all outputs 0; state IDLE; all internal registers 0.
- Reset asserted mid-packet aborts immediately: `o_valid` drops asynchronously and no `o_done` is issued.
- Start latency:
  - `i_start` is sampled at edge N.
  - `o_load` is high in cycle N+1.
  - LEN occupies cycle N+2; at this point the generator output reflects the loaded seed.
  - The first `o_valid`/`o_sop` is in cycle N+3.
- Throughput: one beat per cycle while `i_ready` is high.
- Packet-to-packet spacing with `i_ready` always high: EOP beat, then `gap` idle cycles, then one LEN cycle, then SOP. With gap = 0 there is exactly one bubble.
- `o_done` is high in the cycle after the final EOP handshake. `o_busy` is low in that same cycle.

## Test plan
- **Basic run.** Reset, then start with seed=0x1, pkt_num=3, mask=0x03, gap=2, `i_ready` held high.
  - `o_load` pulses once, in cycle N+1.
  - Exactly 3 SOP and 3 EOP beats occur; each packet length is within 1..4.
  - Each EOP is followed by 2 idle cycles, then the LEN bubble.
  - `o_done` pulses once; `o_pkt_cnt` reads 3.
- **Backpressure.** Drop `i_ready` for 5 cycles mid-packet.
  - `o_data`, `o_sop` and `o_eop` hold stable throughout; no beat is lost or duplicated.
  - Beat count still equals len.
- **Zero mask, zero gap, zero count.**
  - mask=0, gap=0, pkt_num=4: every packet is a single beat with `o_sop = o_eop = 1`, with a single one-cycle bubble between packets.
  - pkt_num=0: `o_done` the cycle after start; `o_load` never asserted.
- **Graceful stop.** Assert `i_stop` during beat 1 of packet 2 with mask=0x07.
  - Packet 2 completes through EOP, then `o_done`; `o_pkt_cnt` = 2.
  - Repeat with `i_stop` asserted in GAP: immediate return to IDLE with `o_done`.
- **Restart and reset abort.**
  - A second run with the same seed reproduces an identical data and length sequence; `o_pkt_cnt` is cleared at the new start.
  - Asserting `rst` mid-packet forces all outputs to 0 at once; there is no `o_done`.

Source files
------------

// File: rtl/rand_pkt_ctrl_if.sv
// Valid/ready packet stream from rand_pkt_ctrl to a cache input port.
// The master drives valid/data/sop/eop; the slave returns ready.
interface rand_pkt_ctrl_if #(
   parameter int DW = 32
);
   logic          o_valid;
   logic          i_ready;
   logic [DW-1:0] o_data;
   logic          o_sop;
   logic          o_eop;

   modport master (
      output o_valid,
      output o_data,
      output o_sop,
      output o_eop,
      input  i_ready
   );

   modport slave (
      input  o_valid,
      input  o_data,
      input  o_sop,
      input  o_eop,
      output i_ready
   );
endinterface

// File: rtl/rand_pkt_ctrl.sv
// Sequencer for gen_rand: seeds the generator, draws a length per packet and frames
// the free-running random words into SOP/EOP packets with inter-packet gaps.
//  state | meaning
//  IDLE  | waiting for an accepted i_start
//  LOAD  | o_load strobe, generator takes the latched seed
//  LEN   | draw packet length and first payload word
//  DATA  | stream beats until the EOP handshake
//  GAP   | inter-packet idle cycles
module rand_pkt_ctrl #(
   parameter int DW    = 32,
   parameter int RW    = 32,
   parameter int LEN_W = 8,
   parameter int PW    = 16,
   parameter int GW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [RW-1:0]    i_seed,
   input  logic [PW-1:0]    i_pkt_num,
   input  logic [LEN_W-1:0] i_len_mask,
   input  logic [GW-1:0]    i_gap,
   input  logic             i_stop,
   input  logic [DW-1:0]    i_rand_data,
   output logic             o_load,
   output logic [RW-1:0]    o_seed,
   output logic             o_busy,
   output logic             o_done,
   output logic [PW-1:0]    o_pkt_cnt,
   rand_pkt_ctrl_if.master  strm
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LEN,
      S_DATA,
      S_GAP
   } state_t;

   localparam logic [LEN_W:0] LEN_ONE = (LEN_W+1)'(1);

   state_t           state_q;
   logic [RW-1:0]    seed_q;
   logic [PW-1:0]    num_q;
   logic [LEN_W-1:0] mask_q;
   logic [GW-1:0]    gap_q;
   logic [GW-1:0]    gcnt_q;
   logic [LEN_W:0]   len_q;
   logic [LEN_W:0]   beat_q;
   logic [PW-1:0]    cnt_q;
   logic             valid_q;
   logic [DW-1:0]    data_q;
   logic             sop_q;
   logic             eop_q;
   logic             load_q;
   logic             done_q;

   logic [LEN_W:0]   len_d;
   logic [LEN_W:0]   beat_d;
   logic [PW-1:0]    cnt_d;

   // One extra bit so a full mask gives lengths up to 2**LEN_W without wrapping.
   assign len_d  = {1'b0, i_rand_data[LEN_W-1:0] & mask_q} + LEN_ONE;
   assign beat_d = beat_q + LEN_ONE;
   assign cnt_d  = cnt_q + PW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         seed_q  <= '0;
         num_q   <= '0;
         mask_q  <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         load_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         load_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  if (i_pkt_num != '0) begin
                     seed_q  <= i_seed;
                     num_q   <= i_pkt_num;
                     mask_q  <= i_len_mask;
                     gap_q   <= i_gap;
                     cnt_q   <= '0;
                     load_q  <= 1'b1;
                     state_q <= S_LOAD;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end

            S_LOAD: begin
               state_q <= S_LEN;
            end

            S_LEN: begin
               len_q   <= len_d;
               data_q  <= i_rand_data;
               beat_q  <= '0;
               valid_q <= 1'b1;
               sop_q   <= 1'b1;
               eop_q   <= (len_d == LEN_ONE);
               state_q <= S_DATA;
            end

            S_DATA: begin
               if (strm.i_ready) begin
                  data_q <= i_rand_data;
                  if (eop_q) begin
                     cnt_q   <= cnt_d;
                     valid_q <= 1'b0;
                     sop_q   <= 1'b0;
                     eop_q   <= 1'b0;
                     if ((cnt_d == num_q) || i_stop) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                     end else if (gap_q == '0) begin
                        state_q <= S_LEN;
                     end else begin
                        gcnt_q  <= gap_q;
                        state_q <= S_GAP;
                     end
                  end else begin
                     beat_q <= beat_d;
                     sop_q  <= 1'b0;
                     eop_q  <= (beat_d == len_q - LEN_ONE);
                  end
               end
            end

            S_GAP: begin
               if (i_stop) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end else if (gcnt_q == GW'(1)) begin
                  state_q <= S_LEN;
               end else begin
                  gcnt_q <= gcnt_q - GW'(1);
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign o_load       = load_q;
   assign o_seed       = seed_q;
   assign o_busy       = (state_q != S_IDLE);
   assign o_done       = done_q;
   assign o_pkt_cnt    = cnt_q;
   assign strm.o_valid = valid_q;
   assign strm.o_data  = data_q;
   assign strm.o_sop   = sop_q;
   assign strm.o_eop   = eop_q;

endmodule

// File: tb/tb_rand_pkt_ctrl.sv
// Bench for rand_pkt_ctrl: a table of whole runs plus hand-written corner sequences,
// with every cycle of the stream checked against framing rules by a monitor.
module tb_rand_pkt_ctrl;
   localparam int DW    = 32;
   localparam int RW    = 32;
   localparam int LEN_W = 8;
   localparam int PW    = 16;
   localparam int GW    = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_start = 1'b0;
   logic [RW-1:0]    i_seed = '0;
   logic [PW-1:0]    i_pkt_num = '0;
   logic [LEN_W-1:0] i_len_mask = '0;
   logic [GW-1:0]    i_gap = '0;
   logic             i_stop = 1'b0;
   logic [DW-1:0]    gen_q;
   logic             o_load;
   logic [RW-1:0]    o_seed;
   logic             o_busy;
   logic             o_done;
   logic [PW-1:0]    o_pkt_cnt;

   int checks   = 0;
   int failures = 0;

   rand_pkt_ctrl_if #(.DW(DW)) strm ();

   rand_pkt_ctrl #(.DW(DW), .RW(RW), .LEN_W(LEN_W), .PW(PW), .GW(GW)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_seed      (i_seed),
      .i_pkt_num   (i_pkt_num),
      .i_len_mask  (i_len_mask),
      .i_gap       (i_gap),
      .i_stop      (i_stop),
      .i_rand_data (gen_q),
      .o_load      (o_load),
      .o_seed      (o_seed),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_pkt_cnt   (o_pkt_cnt),
      .strm        (strm)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] lcg(input logic [31:0] x);
      return x * 32'd1664525 + 32'd1013904223;
   endfunction

   // Stand-in for gen_rand: free-running, seed visible the cycle after o_load.
   always @(posedge clk or posedge rst) begin
      if (rst)         gen_q <= '0;
      else if (o_load) gen_q <= o_seed;
      else             gen_q <= lcg(gen_q);
   end

   typedef struct {
      logic [RW-1:0] seed;
      int            num;
      int            mask;
      int            gap;
      bit            rnd_ready;
      int            exp_cnt;
      int            exp_loads;
      int            max_len;
   } vec_t;

   logic             m_prev_valid, m_prev_ready, m_prev_sop, m_prev_eop;
   logic [DW-1:0]    m_prev_data, m_prev_gen;
   int               m_beat, m_len, m_idle, m_pkts, m_loads, m_dones, m_gap;
   bit               m_done_after_eop;
   logic [LEN_W-1:0] m_mask;
   logic [DW-1:0]    m_data_log[$];
   int               m_len_log[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic mon_reset(input logic [LEN_W-1:0] mask, input int gap);
      m_prev_valid = 0; m_prev_ready = 0; m_prev_sop = 0; m_prev_eop = 0;
      m_prev_data = '0; m_prev_gen = '0;
      m_beat = 0; m_len = 0; m_idle = 0; m_pkts = 0; m_loads = 0; m_dones = 0;
      m_done_after_eop = 0;
      m_mask = mask; m_gap = gap;
      m_data_log.delete();
      m_len_log.delete();
   endtask

   task automatic monitor();
      bit hold, cont;
      hold = m_prev_valid && !m_prev_ready;
      cont = m_prev_valid && m_prev_ready && !m_prev_eop;
      if (o_load) m_loads++;
      if (o_done) begin
         m_dones++;
         m_done_after_eop = m_prev_valid && m_prev_ready && m_prev_eop;
         check("busy_at_done", o_busy, 1'b0);
      end
      if (hold) begin
         check("hold_valid", strm.o_valid, 1'b1);
         check("hold_data", strm.o_data, m_prev_data);
         check("hold_sop", strm.o_sop, m_prev_sop);
         check("hold_eop", strm.o_eop, m_prev_eop);
      end else if (strm.o_valid) begin
         if (cont) begin
            m_beat++;
         end else begin
            check("len_bubble", m_prev_valid, 1'b0);
            if (m_pkts > 0) check("gap_cycles", m_idle, m_gap + 1);
            m_beat = 0;
            m_len  = int'(m_prev_gen[LEN_W-1:0] & m_mask) + 1;
         end
         check("beat_data", strm.o_data, m_prev_gen);
         check("beat_sop", strm.o_sop, m_beat == 0);
         check("beat_eop", strm.o_eop, m_beat == m_len - 1);
      end else if (cont) begin
         check("beat_lost", strm.o_valid, 1'b1);
      end
      if (!strm.o_valid) m_idle++;
      if (strm.o_valid && strm.i_ready) begin
         m_data_log.push_back(strm.o_data);
         if (strm.o_eop) begin
            m_pkts++;
            m_len_log.push_back(m_beat + 1);
            m_idle = 0;
         end
      end
      m_prev_valid = strm.o_valid;
      m_prev_ready = strm.i_ready;
      m_prev_sop   = strm.o_sop;
      m_prev_eop   = strm.o_eop;
      m_prev_data  = strm.o_data;
      m_prev_gen   = gen_q;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [RW-1:0] seed, input int num, input int mask, input int gap);
      mon_reset(LEN_W'(mask), gap);
      i_seed     = seed;
      i_pkt_num  = PW'(num);
      i_len_mask = LEN_W'(mask);
      i_gap      = GW'(gap);
      i_start    = 1'b1;
      tick();
      i_start    = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rnd, output int cyc);
      cyc = 0;
      while (m_dones == 0 && cyc < budget) begin
         strm.i_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         tick();
         cyc++;
      end
      check("done_seen", m_dones != 0, 1'b1);
      strm.i_ready = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          vecs[6];
      int            cyc, mx, exp_len2;
      logic [DW-1:0] s, g;
      logic [DW-1:0] ref_data[$];
      int            ref_len[$];
      bit            same;

      vecs[0] = '{32'h1, 0, 3, 2, 1'b0, 0, 0, 0};
      vecs[1] = '{32'h1, 3, 3, 2, 1'b0, 3, 1, 4};
      vecs[2] = '{32'h1234_5678, 4, 0, 0, 1'b0, 4, 1, 1};
      vecs[3] = '{$urandom, 6, 7, 1, 1'b1, 6, 1, 8};
      vecs[4] = '{$urandom, 5, 8'h1f, 3, 1'b1, 5, 1, 32};
      vecs[5] = '{$urandom, 3, 8'hff, 0, 1'b1, 3, 1, 256};

      strm.i_ready = 1'b1;
      mon_reset('0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_load", o_load, 1'b0);
      check("rst_seed", o_seed, '0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_done", o_done, 1'b0);
      check("rst_pkt_cnt", o_pkt_cnt, '0);
      check("rst_valid", strm.o_valid, 1'b0);
      check("rst_data", strm.o_data, '0);
      check("rst_sop", strm.o_sop, 1'b0);
      check("rst_eop", strm.o_eop, 1'b0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         start_run(vecs[i].seed, vecs[i].num, vecs[i].mask, vecs[i].gap);
         wait_done(8000, vecs[i].rnd_ready, cyc);
         if (vecs[i].num == 0) check("zero_cnt_latency", cyc, 1);
         check("run_pkts", m_pkts, vecs[i].exp_cnt);
         check("run_pkt_cnt", o_pkt_cnt, vecs[i].exp_cnt);
         check("run_loads", m_loads, vecs[i].exp_loads);
         check("run_dones", m_dones, 1);
         check("run_done_after_eop", m_done_after_eop, vecs[i].num != 0);
         mx = 0;
         foreach (m_len_log[j]) if (m_len_log[j] > mx) mx = m_len_log[j];
         check("run_max_len", mx <= vecs[i].max_len, 1'b1);
      end

      // Start latency: load in N+1, LEN in N+2, first beat (the seed word) in N+3.
      start_run(32'h5, 2, 3, 1);
      check("lat_load_n1", o_load, 1'b1);
      check("lat_busy_n1", o_busy, 1'b1);
      check("lat_valid_n1", strm.o_valid, 1'b0);
      check("lat_cnt_clr", o_pkt_cnt, '0);
      tick();
      check("lat_load_n2", o_load, 1'b0);
      check("lat_valid_n2", strm.o_valid, 1'b0);
      tick();
      check("lat_sop_n3", strm.o_valid && strm.o_sop, 1'b1);
      check("lat_first_data", strm.o_data, 32'h5);
      wait_done(500, 1'b0, cyc);
      check("lat_pkt_cnt", o_pkt_cnt, 2);

      // Backpressure mid-packet, with a start attempt while busy.
      start_run(32'h7, 1, 8'hff, 0);
      for (int k = 0; k < 10 && !strm.o_valid; k++) tick();
      check("bp_reach", strm.o_valid, 1'b1);
      repeat (2) tick();
      strm.i_ready = 1'b0;
      i_start   = 1'b1;
      i_pkt_num = '0;
      tick();
      i_start   = 1'b0;
      repeat (4) tick();
      strm.i_ready = 1'b1;
      wait_done(500, 1'b0, cyc);
      check("bp_len", (m_len_log.size() == 1) ? m_len_log[0] : -1, 8);
      check("bp_beats", m_data_log.size(), 8);
      check("bp_loads", m_loads, 1);
      check("bp_dones", m_dones, 1);
      check("bp_pkt_cnt", o_pkt_cnt, 1);

      // Graceful stop during beat 1 of packet 2; seed chosen so packet 2 has >= 2 beats.
      s = 32'h103;
      g = '0;
      for (int t = 0; t < 64; t++) begin
         g = s;
         repeat (6) g = lcg(g);
         if (g[2:0] != 3'd0) break;
         s = s + 32'd8;
      end
      exp_len2 = int'(g[2:0]) + 1;
      start_run(s, 5, 7, 1);
      for (int k = 0; k < 100 && !(m_pkts == 1 && strm.o_valid && !strm.o_sop); k++) tick();
      check("stop_reach_beat1", m_pkts == 1 && strm.o_valid && !strm.o_sop, 1'b1);
      i_stop = 1'b1;
      wait_done(200, 1'b0, cyc);
      i_stop = 1'b0;
      check("stop_pkts", m_pkts, 2);
      check("stop_pkt_cnt", o_pkt_cnt, 2);
      check("stop_len2", (m_len_log.size() == 2) ? m_len_log[1] : -1, exp_len2);
      check("stop_done_after_eop", m_done_after_eop, 1'b1);

      // Stop while in the gap returns to IDLE at once.
      start_run(32'h55, 5, 1, 4);
      for (int k = 0; k < 100 && !(m_pkts == 1 && !strm.o_valid); k++) tick();
      check("gap_reach", m_pkts == 1 && !strm.o_valid && o_busy, 1'b1);
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      check("gap_stop_done", o_done, 1'b1);
      check("gap_stop_idle", o_busy, 1'b0);
      check("gap_stop_cnt", o_pkt_cnt, 1);
      repeat (3) tick();
      check("gap_stop_dones", m_dones, 1);
      check("gap_stop_pkts", m_pkts, 1);

      // Same seed twice gives the same packets.
      start_run(32'hCAFE_0001, 4, 8'h0f, 2);
      wait_done(1000, 1'b0, cyc);
      ref_data = m_data_log;
      ref_len  = m_len_log;
      check("rs_ref_pkts", ref_len.size(), 4);
      start_run(32'hCAFE_0001, 4, 8'h0f, 2);
      check("rs_cnt_clr", o_pkt_cnt, '0);
      wait_done(1000, 1'b0, cyc);
      check("rs_len_n", m_len_log.size(), ref_len.size());
      check("rs_data_n", m_data_log.size(), ref_data.size());
      same = (m_len_log.size() == ref_len.size()) && (m_data_log.size() == ref_data.size());
      if (same) begin
         foreach (ref_len[j])  if (m_len_log[j] != ref_len[j])   same = 1'b0;
         foreach (ref_data[j]) if (m_data_log[j] != ref_data[j]) same = 1'b0;
      end
      check("rs_same_seq", same, 1'b1);

      // Reset mid-packet clears outputs immediately and issues no done.
      start_run(32'h3f, 2, 8'hff, 0);
      for (int k = 0; k < 10 && !strm.o_valid; k++) tick();
      repeat (3) tick();
      check("abort_pre_valid", strm.o_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("abort_valid", strm.o_valid, 1'b0);
      check("abort_sop", strm.o_sop, 1'b0);
      check("abort_eop", strm.o_eop, 1'b0);
      check("abort_data", strm.o_data, '0);
      check("abort_busy", o_busy, 1'b0);
      check("abort_load", o_load, 1'b0);
      check("abort_done", o_done, 1'b0);
      check("abort_pkt_cnt", o_pkt_cnt, '0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      mon_reset('0, 0);
      repeat (5) tick();
      check("abort_no_done", m_dones, 0);
      check("abort_idle", o_busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
